// File: rtl/cpu_step_ctrl_if.sv
// Pipeline-side bundle of the run/step sequencer.
//   bp_en, bp_addr : breakpoint enable and byte address (pipeline -> ctrl)
//   pc_in          : current PC from the PC register      (pipeline -> ctrl)
//   cpu_ce         : one-clk clock-enable pulse           (ctrl -> pipeline)
//   halted         : 1 whenever the sequencer is not in RUN
//   state_o        : 00 HALT, 01 RUN, 10 STEP, 11 BREAK
//   ce_cnt         : count of cpu_ce pulses since reset
// master = the sequencer, slave = the pipeline / display side.
interface cpu_step_ctrl_if;
    localparam int unsigned AddrW = 32;
    localparam int unsigned CntW  = 32;

    logic             bp_en;
    logic [AddrW-1:0] bp_addr;
    logic [AddrW-1:0] pc_in;
    logic             cpu_ce;
    logic             halted;
    logic [1:0]       state_o;
    logic [CntW-1:0]  ce_cnt;

    modport master (
        input  bp_en, bp_addr, pc_in,
        output cpu_ce, halted, state_o, ce_cnt
    );

    modport slave (
        output bp_en, bp_addr, pc_in,
        input  cpu_ce, halted, state_o, ce_cnt
    );
endinterface

// File: rtl/cpu_step_ctrl.sv
// Run/step/breakpoint sequencer for the 5-stage CPU. Issues a registered
// one-clk cpu_ce that gates the pipeline, with prescaled or full-rate free
// run, debounced single-step and a PC-match breakpoint; counts pulses.
// Ports:
//   clk, rstn  : board clock, async active-low reset
//   run_sw     : async level, rising edge requests RUN, low forces HALT
//   fast_sw    : async level, 1 = RUN pulses every clk
//   step_btn   : raw push-button, debounced rising edge = one step
//   bus        : cpu_step_ctrl_if.master (bp_en, bp_addr, pc_in in;
//                cpu_ce, halted, state_o, ce_cnt out)
module cpu_step_ctrl #(
    parameter int unsigned DIV_W     = 25,
    parameter int unsigned DB_CYCLES = 1000000
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            run_sw,
    input  logic            fast_sw,
    input  logic            step_btn,
    cpu_step_ctrl_if.master bus
);
    localparam int unsigned DbW  = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam int unsigned CntW = 32;

    typedef enum logic [1:0] {
        StHalt  = 2'b00,
        StRun   = 2'b01,
        StStep  = 2'b10,
        StBreak = 2'b11
    } state_t;

    logic [1:0]       runSyncQ;
    logic [1:0]       fastSyncQ;
    logic [1:0]       stepSyncQ;
    logic             runPrevQ;
    logic             dbLevelQ;
    logic             dbPrevQ;
    logic [DbW-1:0]   dbCntQ;
    logic [DIV_W-1:0] prescQ;
    state_t           stateQ;
    state_t           stateNext;
    logic             cpuCeQ;
    logic             ceNext;
    logic             armedQ;
    logic             armedNext;
    logic             haltedQ;
    logic [CntW-1:0]  ceCnt;

    logic runSync;
    logic runRise;
    logic stepPulse;
    logic tick;
    logic bpHit;

    assign runSync   = runSyncQ[1];
    assign runRise   = runSync & ~runPrevQ;
    assign stepPulse = dbLevelQ & ~dbPrevQ;
    assign tick      = fastSyncQ[1] | (&prescQ);
    assign bpHit     = bus.bp_en & (bus.pc_in == bus.bp_addr);

    // Input synchronizers and step-button debounce.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            runSyncQ  <= '0;
            fastSyncQ <= '0;
            stepSyncQ <= '0;
            runPrevQ  <= 1'b0;
            dbLevelQ  <= 1'b0;
            dbPrevQ   <= 1'b0;
            dbCntQ    <= '0;
        end else begin
            runSyncQ  <= {runSyncQ[0], run_sw};
            fastSyncQ <= {fastSyncQ[0], fast_sw};
            stepSyncQ <= {stepSyncQ[0], step_btn};
            runPrevQ  <= runSyncQ[1];
            dbPrevQ   <= dbLevelQ;
            // Any sample agreeing with the accepted level restarts the wait.
            if (stepSyncQ[1] == dbLevelQ) begin
                dbCntQ <= '0;
            end else if (dbCntQ == DbW'(DB_CYCLES - 1)) begin
                dbLevelQ <= stepSyncQ[1];
                dbCntQ   <= '0;
            end else begin
                dbCntQ <= dbCntQ + DbW'(1);
            end
        end
    end

    // Prescaler runs only in RUN; it is zero on every entry into RUN.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prescQ <= '0;
        end else if (stateQ == StRun) begin
            prescQ <= prescQ + DIV_W'(1);
        end else begin
            prescQ <= '0;
        end
    end

    // State register, registered outputs and pulse counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stateQ  <= StHalt;
            cpuCeQ  <= 1'b0;
            armedQ  <= 1'b0;
            haltedQ <= 1'b1;
            ceCnt   <= '0;
        end else begin
            stateQ  <= stateNext;
            cpuCeQ  <= ceNext;
            armedQ  <= armedNext;
            haltedQ <= (stateNext != StRun);
            ceCnt   <= ceCnt + CntW'(cpuCeQ);
        end
    end

    // Next-state logic. armed stays clear until the first pulse after RUN
    // entry so resuming from a breakpoint steps past the matching PC.
    always_comb begin
        stateNext = stateQ;
        ceNext    = 1'b0;
        armedNext = armedQ;
        case (stateQ)
            StHalt: begin
                if (runRise) begin
                    stateNext = StRun;
                    armedNext = 1'b0;
                end else if (stepPulse) begin
                    stateNext = StStep;
                end
            end
            StRun: begin
                if (!runSync) begin
                    stateNext = StHalt;
                end else if (tick) begin
                    if (armedQ && bpHit) begin
                        stateNext = StBreak;
                    end else begin
                        ceNext    = 1'b1;
                        armedNext = 1'b1;
                    end
                end
            end
            StStep: begin
                ceNext    = 1'b1;
                stateNext = StHalt;
            end
            StBreak: begin
                if (stepPulse) begin
                    stateNext = StStep;
                end else if (!runSync) begin
                    stateNext = StHalt;
                end
            end
            default: stateNext = StHalt;
        endcase
    end

    assign bus.cpu_ce  = cpuCeQ;
    assign bus.halted  = haltedQ;
    assign bus.state_o = stateQ;
    assign bus.ce_cnt  = ceCnt;
endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Randomised and directed bench for cpu_step_ctrl against a cycle-level
// behavioural model built from the sequencer's rules.
module tb_cpu_step_ctrl;
    localparam int DivW     = 2;
    localparam int DbCycles = 4;
    localparam int Period   = 1 << DivW;

    logic        clk = 1'b0;
    logic        rstn;
    logic        runSw;
    logic        fastSw;
    logic        stepBtn;
    logic        bpEn;
    logic [31:0] bpAddr;
    logic [31:0] pc;

    int nTests = 0;
    int nFail  = 0;

    cpu_step_ctrl_if bus();

    assign bus.pc_in   = pc;
    assign bus.bp_en   = bpEn;
    assign bus.bp_addr = bpAddr;

    cpu_step_ctrl #(.DIV_W(DivW), .DB_CYCLES(DbCycles)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .run_sw   (runSw),
        .fast_sw  (fastSw),
        .step_btn (stepBtn),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Model: 0 HALT, 1 RUN, 2 STEP, 3 BREAK. Values describe the state after
    // the next rising edge once the inputs for that edge have been applied.
    int          mState;
    logic        mCe;
    logic        mArmed;
    logic [31:0] mCnt;
    int          mAge;
    int          diffRun;
    logic        dbLvl;
    logic        dbOld;
    logic        rHist [0:2];
    logic        fHist [0:1];
    logic        sHist [0:1];

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic checkAll(input string tag);
        checkEq({tag, ".cpu_ce"}, 32'(bus.cpu_ce), 32'(mCe));
        checkEq({tag, ".state"},  32'(bus.state_o), 32'(mState));
        checkEq({tag, ".halted"}, 32'(bus.halted), (mState != 1) ? 32'd1 : 32'd0);
        checkEq({tag, ".ce_cnt"}, bus.ce_cnt, mCnt);
    endtask

    task automatic modelReset();
        mState  = 0;
        mCe     = 1'b0;
        mArmed  = 1'b0;
        mCnt    = 32'd0;
        mAge    = 0;
        diffRun = 0;
        dbLvl   = 1'b0;
        dbOld   = 1'b0;
        for (int i = 0; i < 3; i++) rHist[i] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            fHist[i] = 1'b0;
            sHist[i] = 1'b0;
        end
    endtask

    task automatic modelStep();
        logic runNow, runBefore, fastNow, stepNow, pulse, tick, nCe, nArmed;
        int   nState;
        runNow    = rHist[1];
        runBefore = rHist[2];
        fastNow   = fHist[1];
        stepNow   = sHist[1];
        pulse     = dbLvl && !dbOld;
        tick      = fastNow || ((mAge % Period) == Period - 1);
        nState    = mState;
        nCe       = 1'b0;
        nArmed    = mArmed;
        case (mState)
            0: begin
                if (runNow && !runBefore) begin
                    nState = 1;
                    nArmed = 1'b0;
                end else if (pulse) begin
                    nState = 2;
                end
            end
            1: begin
                if (!runNow) nState = 0;
                else if (tick) begin
                    if (mArmed && bpEn && (pc == bpAddr)) nState = 3;
                    else begin
                        nCe    = 1'b1;
                        nArmed = 1'b1;
                    end
                end
            end
            2: begin
                nCe    = 1'b1;
                nState = 0;
            end
            default: begin
                if (pulse) nState = 2;
                else if (!runNow) nState = 0;
            end
        endcase
        if (mCe) mCnt = mCnt + 32'd1;
        mAge  = (mState == 1 && nState == 1) ? mAge + 1 : 0;
        dbOld = dbLvl;
        if (stepNow != dbLvl) begin
            diffRun++;
            if (diffRun == DbCycles) begin
                dbLvl   = stepNow;
                diffRun = 0;
            end
        end else begin
            diffRun = 0;
        end
        rHist[2] = rHist[1];
        rHist[1] = rHist[0];
        rHist[0] = runSw;
        fHist[1] = fHist[0];
        fHist[0] = fastSw;
        sHist[1] = sHist[0];
        sHist[0] = stepBtn;
        mState   = nState;
        mCe      = nCe;
        mArmed   = nArmed;
    endtask

    // One clock: check the DUT, advance the emulated PC, apply new inputs.
    task automatic cycle(input logic r, input logic f, input logic s);
        @(negedge clk);
        checkAll("cyc");
        if (mCe) pc = (pc + 32'd4) & 32'h0000_003C;
        runSw   = r;
        fastSw  = f;
        stepBtn = s;
        modelStep();
    endtask

    task automatic applyReset(input int hold);
        @(posedge clk);
        #2;
        rstn    = 1'b0;
        runSw   = 1'b0;
        fastSw  = 1'b0;
        stepBtn = 1'b0;
        modelReset();
        #1 checkAll("rst_async");
        repeat (hold) begin
            @(negedge clk);
            checkAll("rst_hold");
        end
        rstn = 1'b1;
        modelStep();
    endtask

    initial begin
        logic [31:0] c0;
        logic        seen;
        logic        runR, fastR, stepTarget, stepR;

        rstn    = 1'b0;
        runSw   = 1'b0;
        fastSw  = 1'b0;
        stepBtn = 1'b0;
        bpEn    = 1'b0;
        bpAddr  = 32'h10;
        pc      = 32'h0;
        modelReset();
        @(negedge clk);
        checkAll("reset");
        rstn = 1'b1;
        modelStep();
        repeat (4) cycle(0, 0, 0);

        // Prescaled free run, then full rate.
        c0 = bus.ce_cnt;
        repeat (41) cycle(1, 0, 0);
        checkEq("freerun_cnt_9_10", ((bus.ce_cnt - c0) >= 9 && (bus.ce_cnt - c0) <= 10) ? 32'd1 : 32'd0, 32'd1);
        repeat (4) cycle(1, 1, 0);
        c0 = bus.ce_cnt;
        repeat (10) cycle(1, 1, 0);
        checkEq("fast_every_clk", bus.ce_cnt - c0, 32'd10);

        // Reset asserted in the middle of a full-rate run.
        applyReset(3);
        repeat (4) cycle(0, 0, 0);

        // Bouncing single step from HALT.
        c0 = bus.ce_cnt;
        cycle(0, 0, 1); cycle(0, 0, 0); cycle(0, 0, 1); cycle(0, 0, 0);
        repeat (10) cycle(0, 0, 1);
        repeat (10) cycle(0, 0, 0);
        checkEq("step_one_pulse", bus.ce_cnt - c0, 32'd1);
        checkEq("step_back_halt", 32'(bus.state_o), 32'd0);

        // Breakpoint at 0x10, then resume past it.
        bpEn = 1'b1;
        pc   = 32'h0;
        c0   = bus.ce_cnt;
        for (int i = 0; i < 80 && mState != 3; i++) cycle(1, 0, 0);
        cycle(1, 0, 0);
        checkEq("bp_state", 32'(bus.state_o), 32'd3);
        checkEq("bp_halted", 32'(bus.halted), 32'd1);
        checkEq("bp_pulses", bus.ce_cnt - c0, 32'd4);
        repeat (4) cycle(0, 0, 0);
        c0 = bus.ce_cnt;
        for (int i = 0; i < 20 && bus.ce_cnt == c0; i++) cycle(1, 0, 0);
        checkEq("resume_pulse", bus.ce_cnt - c0, 32'd1);
        checkEq("resume_run", 32'(bus.state_o), 32'd1);
        repeat (4) cycle(0, 0, 0);

        // Break again, then step out of BREAK.
        pc = 32'h0;
        for (int i = 0; i < 80 && mState != 3; i++) cycle(1, 0, 0);
        cycle(1, 0, 0);
        c0   = bus.ce_cnt;
        seen = 1'b0;
        cycle(1, 0, 1); cycle(1, 0, 0);
        for (int i = 0; i < 12; i++) begin
            cycle(1, 0, 1);
            if (bus.state_o == 2'b10) seen = 1'b1;
        end
        repeat (8) cycle(1, 0, 0);
        checkEq("brk_step_seen", 32'(seen), 32'd1);
        checkEq("brk_step_pulse", bus.ce_cnt - c0, 32'd1);
        checkEq("brk_step_halt", 32'(bus.state_o), 32'd0);
        repeat (4) cycle(0, 0, 0);
        bpEn = 1'b0;

        // Step button pressed while running is dropped.
        repeat (6) cycle(1, 0, 0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle(1, 0, (i < 10) ? 1'b1 : 1'b0);
            if (bus.state_o == 2'b10) seen = 1'b1;
        end
        checkEq("run_step_ignored", 32'(seen), 32'd0);
        repeat (6) cycle(0, 0, 0);

        // Run edge and step pulse land on the same cycle: RUN wins.
        for (int i = 0; i < 10; i++) cycle((i >= 4) ? 1'b1 : 1'b0, 1'b0, 1'b1);
        checkEq("coincide_run", 32'(bus.state_o), 32'd1);
        repeat (8) cycle(0, 0, 0);

        // Pulse counter wraps.
        force dut.ceCnt = 32'hFFFF_FFFF;
        mCnt = 32'hFFFF_FFFF;
        cycle(0, 0, 0);
        release dut.ceCnt;
        repeat (2) cycle(0, 0, 0);
        repeat (10) cycle(0, 0, 1);
        repeat (6) cycle(0, 0, 0);
        checkEq("ce_cnt_wrap", bus.ce_cnt, 32'd0);

        // Randomised soak against the model.
        runR = 1'b0; fastR = 1'b0; stepTarget = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) runR = ~runR;
            if ($urandom_range(0, 59) == 0) fastR = ~fastR;
            if ($urandom_range(0, 29) == 0) stepTarget = ~stepTarget;
            stepR = stepTarget ^ ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 99) == 0) bpEn = ~bpEn;
            if ($urandom_range(0, 199) == 0) bpAddr = 32'($urandom_range(0, 15)) << 2;
            if (i == 1500) applyReset(2);
            cycle(runR, fastR, stepR);
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
